// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for alu_master.
// Holds the slave register map, the multiply opcode and the FSM state
// encoding used by the command-to-bus sequencer.
package alu_pkg;

  // Slave register map; only the low three address bits are ever non-zero.
  localparam logic [7:0] ADDR_A      = 8'd0;
  localparam logic [7:0] ADDR_B      = 8'd1;
  localparam logic [7:0] ADDR_OP     = 8'd2;
  localparam logic [7:0] ADDR_START  = 8'd3;
  localparam logic [7:0] ADDR_DONE   = 8'd4;
  localparam logic [7:0] ADDR_CLEAR  = 8'd5;
  localparam logic [7:0] ADDR_RES1   = 8'd6;
  localparam logic [7:0] ADDR_RES2   = 8'd7;

  // Multiply is the only opcode that produces a 64-bit result.
  localparam logic [3:0] OP_MUL = 4'hD;

  // Value read from the done register once the slave has finished.
  localparam logic [1:0] DONE_READY = 2'b11;

  // Sequencer state encoding.
  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_WR_A     = 4'd1;
  localparam state_t ST_WR_B     = 4'd2;
  localparam state_t ST_WR_OP    = 4'd3;
  localparam state_t ST_WR_START = 4'd4;
  localparam state_t ST_POLL     = 4'd5;
  localparam state_t ST_RD_R1    = 4'd6;
  localparam state_t ST_RD_R2    = 4'd7;
  localparam state_t ST_WR_CLR   = 4'd8;
  localparam state_t ST_RESP     = 4'd9;

  // True when the opcode needs the upper result word fetched as well.
  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_master_poll_timer.sv
// poll_timer: counts cycles spent polling the slave done register and flags
// when the poll budget is used up. Only built when POLL_TIMEOUT_EN is defined;
// without that macro the module does not exist and nothing instantiates it.
`ifdef POLL_TIMEOUT_EN
module poll_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  // A zero budget behaves like a budget of one poll.
  localparam int unsigned LIM = (LIMIT < 1) ? 1 : LIMIT;
  localparam int unsigned CW  = $clog2(LIM + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise advance once per counted cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The current cycle is the last allowed poll.
  assign expired = count && (cnt_q == CW'(LIM - 1));

endmodule
`endif

// File: rtl/alu_master.sv
// alu_master: accepts one ALU command, drives it onto a simple register bus
// towards an ALU slave (write A, B, opcode, start; poll done; read results;
// clear), then presents the result until it is taken.
// Optional feature macro: POLL_TIMEOUT_EN -- aborts polling after
// TIMEOUT_CYCLES cycles and reports it on res_err.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. cmd_ready is high only in IDLE; res_valid is high only in RESP,
// during which res_lo/res_hi/res_err do not change.
module alu_master
  import alu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [3:0]  cmd_op,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_lo,
  output logic [31:0] res_hi,
  output logic        res_err,
  output logic        M_sel,
  output logic        M_wr,
  output logic [7:0]  M_addr,
  output logic [31:0] M_dout,
  input  logic [31:0] M_din
);

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic        tmr_expired;

`ifdef POLL_TIMEOUT_EN
  logic res_err_q, res_err_d;

  // Poll budget counter; held clear whenever the sequencer is not polling,
  // so it always starts from zero on entry to POLL.
  poll_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_poll_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != ST_POLL),
    .count  (state_q == ST_POLL),
    .expired(tmr_expired)
  );

  assign res_err = res_err_q;
`else
  assign tmr_expired = 1'b0;
  assign res_err     = 1'b0;
`endif

  assign cmd_ready = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_RESP);
  assign res_lo    = res_lo_q;
  assign res_hi    = res_hi_q;

  // Sequencer: next state, latched command, result capture and bus drive.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
`ifdef POLL_TIMEOUT_EN
    res_err_d = res_err_q;
`endif
    M_sel  = 1'b0;
    M_wr   = 1'b0;
    M_addr = 8'd0;
    M_dout = 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          op_d    = cmd_op;
`ifdef POLL_TIMEOUT_EN
          res_err_d = 1'b0;
`endif
          state_d = ST_WR_A;
        end
      end
      ST_WR_A: begin
        M_sel   = 1'b1;
        M_wr    = 1'b1;
        M_addr  = ADDR_A;
        M_dout  = a_q;
        state_d = ST_WR_B;
      end
      ST_WR_B: begin
        M_sel   = 1'b1;
        M_wr    = 1'b1;
        M_addr  = ADDR_B;
        M_dout  = b_q;
        state_d = ST_WR_OP;
      end
      ST_WR_OP: begin
        M_sel   = 1'b1;
        M_wr    = 1'b1;
        M_addr  = ADDR_OP;
        M_dout  = {28'd0, op_q};
        state_d = ST_WR_START;
      end
      ST_WR_START: begin
        M_sel   = 1'b1;
        M_wr    = 1'b1;
        M_addr  = ADDR_START;
        M_dout  = 32'h1;
        state_d = ST_POLL;
      end
      ST_POLL: begin
        M_sel  = 1'b1;
        M_addr = ADDR_DONE;
        // A finished slave takes priority over a budget that runs out on
        // the same cycle.
        if (M_din[1:0] == DONE_READY) begin
          state_d = ST_RD_R1;
        end else if (tmr_expired) begin
          res_lo_d = 32'd0;
          res_hi_d = 32'd0;
`ifdef POLL_TIMEOUT_EN
          res_err_d = 1'b1;
`endif
          state_d  = ST_WR_CLR;
        end
      end
      ST_RD_R1: begin
        M_sel    = 1'b1;
        M_addr   = ADDR_RES1;
        res_lo_d = M_din;
        if (is_mul(op_q)) begin
          state_d = ST_RD_R2;
        end else begin
          res_hi_d = 32'd0;
          state_d  = ST_WR_CLR;
        end
      end
      ST_RD_R2: begin
        M_sel    = 1'b1;
        M_addr   = ADDR_RES2;
        res_hi_d = M_din;
        state_d  = ST_WR_CLR;
      end
      ST_WR_CLR: begin
        M_sel   = 1'b1;
        M_wr    = 1'b1;
        M_addr  = ADDR_CLEAR;
        M_dout  = 32'h1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      op_q     <= 4'd0;
      res_lo_q <= 32'd0;
      res_hi_q <= 32'd0;
`ifdef POLL_TIMEOUT_EN
      res_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
`ifdef POLL_TIMEOUT_EN
      res_err_q <= res_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_master.sv
// tb_alu_master: directed table-driven bench for alu_master with a
// behavioural ALU slave on the register bus.
module tb_alu_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic [3:0]  cmd_op = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_lo, res_hi;
  logic        res_err;
  logic        M_sel, M_wr;
  logic [7:0]  M_addr;
  logic [31:0] M_dout;
  logic [31:0] M_din;

  alu_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_lo(res_lo), .res_hi(res_hi), .res_err(res_err),
    .M_sel(M_sel), .M_wr(M_wr), .M_addr(M_addr),
    .M_dout(M_dout), .M_din(M_din)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0] s_a = '0, s_b = '0, s_r1 = '0, s_r2 = '0;
  logic [3:0]  s_op = '0;
  logic        s_pending = 1'b0;
  int          s_wait = 0;
  int          wait_cfg = 0;
  logic        stuck = 1'b0;

  function automatic logic [63:0] slave_calc(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
    logic [63:0] r;
    case (op)
      4'h0: r = {32'd0, a} + {32'd0, b};
      4'h1: r = {32'd0, a - b};
      4'h2: r = {32'd0, a & b};
      4'h3: r = {32'd0, a | b};
      4'h4: r = {32'd0, a ^ b};
      4'hD: r = {32'd0, a} * {32'd0, b};
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (M_sel && M_wr) begin
      case (M_addr)
        8'd0: s_a <= M_dout;
        8'd1: s_b <= M_dout;
        8'd2: s_op <= M_dout[3:0];
        8'd3: begin
          {s_r2, s_r1} <= slave_calc(s_a, s_b, s_op);
          s_pending <= 1'b1;
          s_wait <= wait_cfg;
        end
        8'd5: s_pending <= 1'b0;
        default: ;
      endcase
    end else if (M_sel && M_addr == 8'd4 && s_wait > 0) begin
      s_wait <= s_wait - 1;
    end
  end

  always_comb begin
    M_din = 32'd0;
    if (M_sel && !M_wr) begin
      case (M_addr)
        8'd4: begin
          if (stuck) M_din = 32'd2;
          else if (s_pending && s_wait == 0) M_din = 32'd3;
        end
        8'd6: M_din = s_r1;
        8'd7: M_din = s_r2;
        default: M_din = 32'd0;
      endcase
    end
  end

  // ---------------- bus monitor / scoreboard ----------------
  logic [39:0] exp_q[$];
  int rd4 = 0;
  int rd7 = 0;

  always @(negedge clk) begin
    if (M_sel && M_wr) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", M_addr, M_dout);
      end else begin
        check("bus_write", {24'd0, M_addr, M_dout}, {24'd0, exp_q.pop_front()});
      end
    end else if (M_sel) begin
      if (M_addr == 8'd4) rd4++;
      if (M_addr == 8'd7) rd7++;
    end else begin
      check("idle_bus", {23'd0, M_wr, M_addr, M_dout}, 64'd0);
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    int          wait_n;
    logic        stuck;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    logic        exp_err;
    int          exp_lat;
    int          exp_polls;
    int          exp_r2;
  } vec_t;

  vec_t vecs[9];

  task automatic push_writes(input vec_t v, input bit with_clear);
    exp_q.push_back({8'd0, v.a});
    exp_q.push_back({8'd1, v.b});
    exp_q.push_back({8'd2, 28'd0, v.op});
    exp_q.push_back({8'd3, 32'h1});
    if (with_clear) exp_q.push_back({8'd5, 32'h1});
  endtask

  // Called just after an accepting edge; counts edges until res_valid.
  task automatic wait_result(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (res_valid) break;
      if (lat >= 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL res_valid_timeout: got no res_valid expected within 100 cycles");
        break;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_cmd(input vec_t v, input int hold);
    int lat;
    int p4;
    int p7;
    wait_cfg = v.wait_n;
    stuck = v.stuck;
    push_writes(v, 1'b1);
    p4 = rd4;
    p7 = rd7;
    @(negedge clk);
    check("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_a = v.a;
    cmd_b = v.b;
    cmd_op = v.op;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_a = 32'hDEAD_BEEF;
    wait_result(lat);
    check("latency", 64'(lat), 64'(v.exp_lat));
    check("res_lo", {32'd0, res_lo}, {32'd0, v.exp_lo});
    check("res_hi", {32'd0, res_hi}, {32'd0, v.exp_hi});
    check("res_err", {63'd0, res_err}, {63'd0, v.exp_err});
    check("cmd_ready_busy", {63'd0, cmd_ready}, 64'd0);
    check("poll_reads", 64'(rd4 - p4), 64'(v.exp_polls));
    check("res2_reads", 64'(rd7 - p7), 64'(v.exp_r2));
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      cmd_a = 32'h1111_0000 + 32'(i);
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", {63'd0, res_valid}, 64'd1);
      check("hold_lo", {32'd0, res_lo}, {32'd0, v.exp_lo});
      check("hold_hi", {32'd0, res_hi}, {32'd0, v.exp_hi});
      check("hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    check("back_to_idle", {62'd0, cmd_ready, res_valid}, 64'd2);
    check("writes_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end expected end of test");
    $fatal(1, "global timeout");
  end

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    bit found;
    vec_t v2;
    //          a             b             op     wt st  lo            hi            err lat polls r2
    vecs[0] = '{32'd5,        32'd7,        4'h0,  0, 0, 32'd12,       32'd0,        0,  7,  1,    0};
    vecs[1] = '{32'hFFFF_FFFF,32'd2,        4'hD,  0, 0, 32'hFFFF_FFFE,32'd1,        0,  8,  1,    1};
    vecs[2] = '{32'd10,       32'd3,        4'h1,  2, 0, 32'd7,        32'd0,        0,  9,  3,    0};
    vecs[3] = '{32'hF0F0_F0F0,32'h0FF0_0FF0,4'h2,  1, 0, 32'h00F0_00F0,32'd0,        0,  8,  2,    0};
    vecs[4] = '{32'h1234_0000,32'h0000_5678,4'h3,  0, 0, 32'h1234_5678,32'd0,        0,  7,  1,    0};
    vecs[5] = '{32'hAAAA_AAAA,32'hFFFF_FFFF,4'h4,  0, 0, 32'h5555_5555,32'd0,        0,  7,  1,    0};
    vecs[6] = '{32'h0001_0000,32'h0001_0000,4'hD,  3, 0, 32'd0,        32'd1,        0,  11, 4,    1};
    vecs[7] = '{32'd3,        32'd4,        4'hD,  0, 0, 32'd12,       32'd0,        0,  8,  1,    1};
    vecs[8] = '{32'hFFFF_FFFF,32'd1,        4'h0,  0, 0, 32'd0,        32'd0,        0,  7,  1,    0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("rst_res_valid", {63'd0, res_valid}, 64'd0);
    check("rst_results", {res_hi, res_lo}, 64'd0);
    check("rst_err_sel", {62'd0, res_err, M_sel}, 64'd0);

    // Table
    for (int i = 0; i < 9; i++) run_cmd(vecs[i], 0);

    // Backpressure: result held for 10 cycles while a command is offered
    run_cmd(vecs[1], 10);

    // Back-to-back with cmd_valid held and res_ready high
    v2 = vecs[0];
    v2.a = 32'd100;
    v2.b = 32'd23;
    wait_cfg = 0;
    stuck = 1'b0;
    push_writes(vecs[0], 1'b1);
    push_writes(v2, 1'b1);
    @(negedge clk);
    check("b2b_ready", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_a = 32'd5;
    cmd_b = 32'd7;
    cmd_op = 4'h0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_a = 32'd100;
    cmd_b = 32'd23;
    wait_result(lat);
    check("b2b_lat1", 64'(lat), 64'd7);
    check("b2b_lo1", {32'd0, res_lo}, 64'd12);
    @(posedge clk);
    @(negedge clk);
    check("b2b_idle_gap", {62'd0, cmd_ready, res_valid}, 64'd2);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_result(lat);
    check("b2b_lat2", 64'(lat), 64'd7);
    check("b2b_lo2", {32'd0, res_lo}, 64'd123);
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    check("b2b_drained", 64'(exp_q.size()), 64'd0);

    // Reset while polling: no clear write, outputs back to reset values
    wait_cfg = 50;
    push_writes(vecs[4], 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_a = vecs[4].a;
    cmd_b = vecs[4].b;
    cmd_op = vecs[4].op;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (M_sel && !M_wr && M_addr == 8'd4) begin
        found = 1'b1;
        break;
      end
    end
    check("reached_poll", {63'd0, found}, 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstpoll_idle", {61'd0, cmd_ready, res_valid, M_sel}, 64'd4);
    check("rstpoll_results", {res_hi, res_lo}, 64'd0);
    repeat (5) @(negedge clk);
    check("rstpoll_no_clear", 64'(exp_q.size()), 64'd0);

    // Recovery after reset
    run_cmd(vecs[0], 0);

`ifdef POLL_TIMEOUT_EN
    // Done stuck at 2: abort after 4 polls, then a normal command clears err
    v2 = '{32'd5, 32'd7, 4'h0, 0, 1, 32'd0, 32'd0, 1, 9, 4, 0};
    run_cmd(v2, 0);
    run_cmd(vecs[0], 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_master.md
ALU_MASTER -- requirements
Module: alu_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of POLL cycles before abort (used only with POLL_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command present.
REQ-005 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-006 SHALL have ports cmd_a, cmd_b  input  32 each  operands.
REQ-007 SHALL have port cmd_op  input  4  ALU opcode; 4'hD = multiply.
REQ-008 SHALL have ports res_valid  output  1, res_ready  input  1  result handshake.
REQ-009 SHALL have ports res_lo, res_hi  output  32 each  result words; res_err  output  1  timeout abort.
REQ-010 SHALL have ports M_sel  output  1, M_wr  output  1, M_addr  output  8, M_dout  output  32, M_din  input  32  bus master driving the ALU slave.

Function
REQ-011 Single clock domain, one bus access per cycle; M_din sampled combinationally in the same cycle as a read (M_sel=1, M_wr=0).
REQ-012 Slave map: 0 A, 1 B, 2 opcode, 3 start, 4 done, 5 clear, 6 result1, 7 result2; M_addr[7:3]=0.
REQ-013 States: IDLE, WR_A, WR_B, WR_OP, WR_START, POLL, RD_R1, RD_R2, WR_CLR, RESP.
REQ-014 IDLE: cmd_ready=1, M_sel=0; cmd_valid&&cmd_ready latches cmd_a/cmd_b/cmd_op, next WR_A.
REQ-015 WR_A/WR_B/WR_OP: M_sel=1, M_wr=1, addr 0/1/2, M_dout = latched A/B/{28'b0,op}; advance each cycle.
REQ-016 WR_START: write 32'h1 to addr 3, next POLL.
REQ-017 POLL: read addr 4; M_din[1:0]==2'b11 -> RD_R1, else stay.
REQ-018 RD_R1: read addr 6 into res_lo; next RD_R2 if op==4'hD, else WR_CLR with res_hi=0.
REQ-019 RD_R2: read addr 7 into res_hi, next WR_CLR.
REQ-020 WR_CLR: write 32'h1 to addr 5, next RESP.
REQ-021 RESP: res_valid=1, outputs held stable; res_valid&&res_ready -> IDLE; cmd_ready=0 outside IDLE.
REQ-022 Idle bus (M_sel=0): M_wr=0, M_addr=0, M_dout=0.
REQ-023 Non-MUL latency from accept to res_valid SHALL be 7 cycles plus POLL cycles beyond the first.

Reset
REQ-024 reset SHALL force IDLE, cmd_ready=1, res_valid=0, res_lo=res_hi=0, res_err=0, bus idle, timeout counter 0, including mid-operation.
REQ-025 Reset mid-operation SHALL NOT issue a clear write; software issues a fresh command after reset.

Configuration
REQ-026 Macro POLL_TIMEOUT_EN defined: counter counts POLL cycles; reaching TIMEOUT_CYCLES -> WR_CLR with res_lo=res_hi=0, res_err=1; counter cleared on entering POLL.
REQ-027 Macro undefined: POLL waits indefinitely, res_err tied 0, no counter logic.

Structure
REQ-028 Shared package alu_pkg SHALL hold slave address constants, OP_MUL=4'hD, and the state enumeration.
REQ-029 One sub-module poll_timer (counter, load/clear/expire) SHALL be instantiated only under POLL_TIMEOUT_EN.

Verification
REQ-030 ADD: A=5, B=7, op ADD, slave model -> bus writes 0,1,2,3 in order, res_lo=12, res_hi=0, res_err=0, clear write seen.
REQ-031 MUL: A=32'hFFFF_FFFF, B=2, op 4'hD -> RD_R2 visited, res_hi=1, res_lo=32'hFFFF_FFFE.
REQ-032 Backpressure: res_ready=0 for 10 cycles -> res_valid and results stable, cmd_ready=0, cmd_valid ignored.
REQ-033 Reset asserted during POLL -> next cycle IDLE, res_valid=0, M_sel=0, no clear write.
REQ-034 POLL_TIMEOUT_EN, TIMEOUT_CYCLES=4, done stuck at 2 -> after 4 POLL cycles clear write, res_err=1, results 0.
REQ-035 Back-to-back: cmd_valid held high, res_ready=1 -> second command accepted the cycle after RESP exits.
